// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing the single data-memory port between two requesters; one transaction in flight.
// Latency: response pulse 2 cycles after handshake; req_ready only in IDLE, responses are not back-pressured.
module dmem_arbiter #(
    parameter int REG_WIDTH = 64,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [1:0]           req_valid,
    output logic [1:0]           req_ready,
    input  logic [1:0]           req_write,
    input  logic [1:0]           req_sign,
    input  logic [1:0]           req_width0,
    input  logic [1:0]           req_width1,
    input  logic [REG_WIDTH-1:0] req_addr0,
    input  logic [REG_WIDTH-1:0] req_addr1,
    input  logic [REG_WIDTH-1:0] req_wdata0,
    input  logic [REG_WIDTH-1:0] req_wdata1,
    output logic [1:0]           rsp_valid,
    output logic [REG_WIDTH-1:0] rsp_rdata,
    output logic                 rsp_err,
    output logic                 MemRead,
    output logic                 MemWrite,
    output logic                 MemSign,
    output logic [1:0]           MemWidth,
    output logic [REG_WIDTH-1:0] full_addr,
    output logic [REG_WIDTH-1:0] wdata,
    input  logic [REG_WIDTH-1:0] rdata,
    output logic [CNT_WIDTH-1:0] cnt0,
    output logic [CNT_WIDTH-1:0] cnt1
);
    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

    state_t                 state_q, state_d;
    logic                   rr_q, rr_d;
    logic                   owner_q, owner_d;
    logic                   write_q, write_d;
    logic                   sign_q, sign_d;
    logic [1:0]             width_q, width_d;
    logic [REG_WIDTH-1:0]   addr_q, addr_d;
    logic [REG_WIDTH-1:0]   wdata_q, wdata_d;
    logic [REG_WIDTH-1:0]   rdata_q, rdata_d;
    logic                   err_q, err_d;
    logic [CNT_WIDTH-1:0]   cnt0_q, cnt0_d;
    logic [CNT_WIDTH-1:0]   cnt1_q, cnt1_d;

    logic [1:0] grant;
    logic       win;
    logic       aligned;

    // Reset gates ready so nothing can appear accepted while the block is held in reset.
    always_comb begin
        grant = 2'b00;
        if (state_q == S_IDLE && rst_n) begin
            case (req_valid)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = rr_q ? 2'b10 : 2'b01;
                default: grant = 2'b00;
            endcase
        end
    end

    assign req_ready = grant;
    assign win       = grant[1];

    always_comb begin
        case (width_q)
            2'd0:    aligned = 1'b1;
            2'd1:    aligned = ~addr_q[0];
            2'd2:    aligned = (addr_q[1:0] == 2'b00);
            default: aligned = (addr_q[2:0] == 3'b000);
        endcase
    end

    always_comb begin
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        MemSign   = 1'b0;
        MemWidth  = 2'd0;
        full_addr = '0;
        wdata     = '0;
        if (state_q == S_ACCESS && aligned) begin
            MemRead   = ~write_q;
            MemWrite  = write_q;
            MemSign   = sign_q;
            MemWidth  = width_q;
            full_addr = addr_q;
            wdata     = wdata_q;
        end
    end

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        owner_d = owner_q;
        write_d = write_q;
        sign_d  = sign_q;
        width_d = width_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        cnt0_d  = cnt0_q;
        cnt1_d  = cnt1_q;
        case (state_q)
            S_IDLE: begin
                if (|grant) begin
                    owner_d = win;
                    write_d = req_write[win];
                    sign_d  = req_sign[win];
                    width_d = win ? req_width1 : req_width0;
                    addr_d  = win ? req_addr1  : req_addr0;
                    wdata_d = win ? req_wdata1 : req_wdata0;
                    state_d = S_ACCESS;
                end
            end
            S_ACCESS: begin
                rdata_d = (aligned && !write_q) ? rdata : '0;
                err_d   = ~aligned;
                state_d = S_RESP;
            end
            S_RESP: begin
                if (owner_q) begin
                    if (cnt1_q != '1) cnt1_d = cnt1_q + CNT_WIDTH'(1);
                end else begin
                    if (cnt0_q != '1) cnt0_d = cnt0_q + CNT_WIDTH'(1);
                end
                rr_d    = ~owner_q;
                rdata_d = '0;
                err_d   = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            rr_q    <= 1'b0;
            owner_q <= 1'b0;
            write_q <= 1'b0;
            sign_q  <= 1'b0;
            width_q <= 2'd0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            cnt0_q  <= '0;
            cnt1_q  <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            owner_q <= owner_d;
            write_q <= write_d;
            sign_q  <= sign_d;
            width_q <= width_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            cnt0_q  <= cnt0_d;
            cnt1_q  <= cnt1_d;
        end
    end

    assign rsp_valid = (state_q == S_RESP) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
    assign cnt0      = cnt0_q;
    assign cnt1      = cnt1_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: byte-array memory environment plus a byte-level reference model and randomized traffic.
module tb_dmem_arbiter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [1:0]  req_valid, req_write, req_sign, req_width0, req_width1;
    logic [63:0] req_addr0, req_addr1, req_wdata0, req_wdata1;
    logic [1:0]  req_ready, rsp_valid;
    logic [63:0] rsp_rdata;
    logic        rsp_err, MemRead, MemWrite, MemSign;
    logic [1:0]  MemWidth;
    logic [63:0] full_addr, wdata, mem_rdata, raw;
    logic [15:0] cnt0, cnt1;

    logic [1:0]  s_req_valid, s_req_ready, s_rsp_valid, s_MemWidth, s_cnt0, s_cnt1;
    logic [63:0] s_rsp_rdata, s_full_addr, s_wdata;
    logic        s_rsp_err, s_MemRead, s_MemWrite, s_MemSign;

    int n_cmp = 0;
    int n_fail = 0;

    logic [7:0] mem [0:255];
    logic [7:0] ref_mem [0:255];
    logic       mem_clr;

    dmem_arbiter #(.REG_WIDTH(64), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_sign(req_sign), .req_width0(req_width0), .req_width1(req_width1),
        .req_addr0(req_addr0), .req_addr1(req_addr1), .req_wdata0(req_wdata0), .req_wdata1(req_wdata1),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .MemRead(MemRead), .MemWrite(MemWrite), .MemSign(MemSign), .MemWidth(MemWidth),
        .full_addr(full_addr), .wdata(wdata), .rdata(mem_rdata), .cnt0(cnt0), .cnt1(cnt1)
    );

    dmem_arbiter #(.REG_WIDTH(64), .CNT_WIDTH(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .req_valid(s_req_valid), .req_ready(s_req_ready),
        .req_write(2'b00), .req_sign(2'b11), .req_width0(2'd0), .req_width1(2'd0),
        .req_addr0(64'd0), .req_addr1(64'd0), .req_wdata0(64'd0), .req_wdata1(64'd0),
        .rsp_valid(s_rsp_valid), .rsp_rdata(s_rsp_rdata), .rsp_err(s_rsp_err),
        .MemRead(s_MemRead), .MemWrite(s_MemWrite), .MemSign(s_MemSign), .MemWidth(s_MemWidth),
        .full_addr(s_full_addr), .wdata(s_wdata), .rdata(64'd0), .cnt0(s_cnt0), .cnt1(s_cnt1)
    );

    // Memory environment: little-endian byte array, combinational read, write on the clock edge.
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
        end else if (MemWrite) begin
            for (int i = 0; i < 8; i++)
                if (i < (1 << MemWidth)) mem[full_addr[7:0] + 8'(i)] <= wdata[8*i +: 8];
        end
    end

    assign raw = {mem[full_addr[7:0] + 8'd7], mem[full_addr[7:0] + 8'd6], mem[full_addr[7:0] + 8'd5],
                  mem[full_addr[7:0] + 8'd4], mem[full_addr[7:0] + 8'd3], mem[full_addr[7:0] + 8'd2],
                  mem[full_addr[7:0] + 8'd1], mem[full_addr[7:0]]};

    always_comb begin
        case (MemWidth)
            2'd0:    mem_rdata = MemSign ? {56'd0, raw[7:0]}  : {{56{raw[7]}}, raw[7:0]};
            2'd1:    mem_rdata = MemSign ? {48'd0, raw[15:0]} : {{48{raw[15]}}, raw[15:0]};
            2'd2:    mem_rdata = MemSign ? {32'd0, raw[31:0]} : {{32{raw[31]}}, raw[31:0]};
            default: mem_rdata = raw;
        endcase
    end

    function automatic logic [63:0] ref_load(input logic [63:0] a, input logic [1:0] w, input logic sg);
        int n;
        logic [63:0] v;
        n = 1 << w;
        v = 64'd0;
        for (int i = 0; i < n; i++) v = v | (64'(ref_mem[8'(a + 64'(i))]) << (8 * i));
        if (!sg && n < 8 && v[8*n-1]) v = v | ~((64'd1 << (8 * n)) - 64'd1);
        return v;
    endfunction

    task automatic ref_store(input logic [63:0] a, input logic [1:0] w, input logic [63:0] d);
        for (int i = 0; i < (1 << w); i++) ref_mem[8'(a + 64'(i))] = d[8*i +: 8];
    endtask

    // Drives one request from a negedge and waits for its response; lat = -1 if ready or response never arrives.
    task automatic issue(input int r, input logic wr, input logic sg, input logic [1:0] w,
                         input logic [63:0] a, input logic [63:0] d,
                         output logic [1:0] o_v, output logic [63:0] o_d, output logic o_e,
                         output int lat, output logic mw_seen);
        logic ok;
        o_v = 2'b00; o_d = 64'd0; o_e = 1'b0; lat = -1; mw_seen = 1'b0; ok = 1'b0;
        if (r == 0) begin req_width0 = w; req_addr0 = a; req_wdata0 = d; end
        else        begin req_width1 = w; req_addr1 = a; req_wdata1 = d; end
        req_write[r] = wr; req_sign[r] = sg; req_valid[r] = 1'b1;
        for (int k = 0; k < 20; k++) begin
            #1;
            if (req_ready[r]) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        if (!ok) begin req_valid[r] = 1'b0; return; end
        @(posedge clk);
        #1 req_valid[r] = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            mw_seen = mw_seen | MemWrite;
            if (rsp_valid != 2'b00) begin
                o_v = rsp_valid; o_d = rsp_rdata; o_e = rsp_err; lat = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; mem_clr = 1'b1;
        req_valid = 2'b00; req_write = 2'b00; req_sign = 2'b00; req_width0 = 2'd0; req_width1 = 2'd0;
        req_addr0 = 64'd0; req_addr1 = 64'd0; req_wdata0 = 64'd0; req_wdata1 = 64'd0; s_req_valid = 2'b00;
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
        repeat (2) @(negedge clk);
        n_cmp++; if (rsp_valid !== 2'b00) begin n_fail++; $display("FAIL reset_rsp_valid got %b exp 00", rsp_valid); end
        n_cmp++; if ({rsp_err, rsp_rdata} !== 65'd0) begin n_fail++; $display("FAIL reset_rsp_data got %h/%b exp 0", rsp_rdata, rsp_err); end
        n_cmp++; if ({cnt0, cnt1} !== 32'd0) begin n_fail++; $display("FAIL reset_cnt got %0d/%0d exp 0/0", cnt0, cnt1); end
        n_cmp++; if ({MemRead, MemWrite, MemSign, MemWidth, full_addr, wdata} !== 133'd0) begin
            n_fail++; $display("FAIL reset_mem_ctrl got R%b W%b S%b w%0d a%h d%h exp all 0", MemRead, MemWrite, MemSign, MemWidth, full_addr, wdata); end
        req_valid = 2'b11; #1;
        n_cmp++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL reset_ready got %b exp 00", req_ready); end
        req_valid = 2'b00;
        @(negedge clk);
        mem_clr = 1'b0; rst_n = 1'b1;
    endtask

    task automatic test_round_robin();
        int order[$];
        int viol;
        viol = 0;
        req_write = 2'b00; req_sign = 2'b00; req_width0 = 2'd3; req_width1 = 2'd3;
        req_addr0 = 64'h0; req_addr1 = 64'h8; req_valid = 2'b11;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (req_ready === 2'b11) viol++;
            if (rsp_valid != 2'b00) order.push_back(rsp_valid[1] ? 1 : 0);
            if (order.size() == 4) break;
        end
        req_valid = 2'b00;
        n_cmp++; if (order.size() != 4) begin n_fail++; $display("FAIL rr_count got %0d exp 4", order.size()); end
        for (int i = 0; i < order.size(); i++) begin
            n_cmp++; if (order[i] != i % 2) begin n_fail++; $display("FAIL rr_order[%0d] got %0d exp %0d", i, order[i], i % 2); end
        end
        n_cmp++; if (viol != 0) begin n_fail++; $display("FAIL rr_ready_both got %0d cycles exp 0", viol); end
        @(negedge clk);
        n_cmp++; if (cnt0 !== 16'd2 || cnt1 !== 16'd2) begin n_fail++; $display("FAIL rr_cnt got %0d/%0d exp 2/2", cnt0, cnt1); end
    endtask

    task automatic test_store_load_dword();
        logic [1:0] v; logic [63:0] d; logic e, mw; int lat;
        issue(0, 1'b1, 1'b0, 2'd3, 64'h10, 64'h1122334455667788, v, d, e, lat, mw);
        ref_store(64'h10, 2'd3, 64'h1122334455667788);
        n_cmp++; if (v !== 2'b01 || lat != 2) begin n_fail++; $display("FAIL dw_store_rsp got v=%b lat=%0d exp v=01 lat=2", v, lat); end
        n_cmp++; if (d !== 64'd0 || e !== 1'b0) begin n_fail++; $display("FAIL dw_store_data got %h/%b exp 0/0", d, e); end
        issue(0, 1'b0, 1'b0, 2'd3, 64'h10, 64'd0, v, d, e, lat, mw);
        n_cmp++; if (v !== 2'b01 || lat != 2) begin n_fail++; $display("FAIL dw_load_rsp got v=%b lat=%0d exp v=01 lat=2", v, lat); end
        n_cmp++; if (d !== 64'h1122334455667788 || e !== 1'b0) begin n_fail++; $display("FAIL dw_load_data got %h/%b exp 1122334455667788/0", d, e); end
    endtask

    task automatic test_byte_sign();
        logic [1:0] v; logic [63:0] d; logic e, mw; int lat;
        issue(0, 1'b1, 1'b0, 2'd0, 64'h20, 64'h80, v, d, e, lat, mw);
        ref_store(64'h20, 2'd0, 64'h80);
        issue(0, 1'b0, 1'b0, 2'd0, 64'h20, 64'd0, v, d, e, lat, mw);
        n_cmp++; if (d !== 64'hFFFFFFFFFFFFFF80 || v !== 2'b01) begin n_fail++; $display("FAIL byte_sext got %h v=%b exp ffffffffffffff80 v=01", d, v); end
        issue(0, 1'b0, 1'b1, 2'd0, 64'h20, 64'd0, v, d, e, lat, mw);
        n_cmp++; if (d !== 64'h80 || v !== 2'b01) begin n_fail++; $display("FAIL byte_zext got %h v=%b exp 80 v=01", d, v); end
    endtask

    task automatic test_misaligned();
        logic [1:0] v; logic [63:0] d; logic e, mw; int lat;
        logic [15:0] c1;
        c1 = cnt1;
        issue(1, 1'b1, 1'b0, 2'd2, 64'h13, 64'hCAFEBABE, v, d, e, lat, mw);
        n_cmp++; if (mw !== 1'b0) begin n_fail++; $display("FAIL mis_memwrite got %b exp 0", mw); end
        n_cmp++; if (v !== 2'b10 || e !== 1'b1 || d !== 64'd0) begin n_fail++; $display("FAIL mis_rsp got v=%b e=%b d=%h exp 10/1/0", v, e, d); end
        @(negedge clk);
        n_cmp++; if (cnt1 !== c1 + 16'd1) begin n_fail++; $display("FAIL mis_cnt1 got %0d exp %0d", cnt1, c1 + 16'd1); end
    endtask

    task automatic test_random();
        logic [1:0] v, w; logic [63:0] d, a, wd, exp_d; logic e, mw, wr, sg, exp_e; int lat, r, sz;
        int exp_c[2];
        exp_c[0] = int'(cnt0); exp_c[1] = int'(cnt1);
        for (int it = 0; it < 40; it++) begin
            r = $urandom_range(0, 1); wr = 1'($urandom_range(0, 1)); sg = 1'($urandom_range(0, 1));
            w = 2'($urandom_range(0, 3)); sz = 1 << w;
            a = 64'($urandom_range(0, 63));
            if ($urandom_range(0, 3) != 0) a = a & ~64'(sz - 1);
            wd = {$urandom, $urandom};
            exp_e = (int'(a) % sz) != 0;
            exp_d = (exp_e || wr) ? 64'd0 : ref_load(a, w, sg);
            issue(r, wr, sg, w, a, wd, v, d, e, lat, mw);
            if (wr && !exp_e) ref_store(a, w, wd);
            exp_c[r]++;
            n_cmp++; if (v !== (r == 1 ? 2'b10 : 2'b01) || lat != 2) begin n_fail++; $display("FAIL rnd%0d_rsp got v=%b lat=%0d exp r=%0d lat=2", it, v, lat, r); end
            n_cmp++; if (e !== exp_e) begin n_fail++; $display("FAIL rnd%0d_err got %b exp %b", it, e, exp_e); end
            n_cmp++; if (d !== exp_d) begin n_fail++; $display("FAIL rnd%0d_data got %h exp %h", it, d, exp_d); end
        end
        @(negedge clk);
        n_cmp++; if (int'(cnt0) != exp_c[0] || int'(cnt1) != exp_c[1]) begin
            n_fail++; $display("FAIL rnd_cnt got %0d/%0d exp %0d/%0d", cnt0, cnt1, exp_c[0], exp_c[1]); end
    endtask

    task automatic test_reset_in_access();
        logic [1:0] v; logic [63:0] d; logic e, mw, ok; int lat;
        issue(0, 1'b1, 1'b0, 2'd3, 64'h40, 64'hA5A5000102030405, v, d, e, lat, mw);
        ref_store(64'h40, 2'd3, 64'hA5A5000102030405);
        req_write[0] = 1'b1; req_width0 = 2'd3; req_addr0 = 64'h40; req_wdata0 = 64'hDEADBEEFDEADBEEF; req_valid[0] = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 10; k++) begin
            #1;
            if (req_ready[0]) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL rst_acc_grant got %b exp 1", ok); end
        @(posedge clk);
        #1 req_valid[0] = 1'b0;
        @(negedge clk);
        n_cmp++; if (MemWrite !== 1'b1) begin n_fail++; $display("FAIL rst_acc_memwrite_pre got %b exp 1", MemWrite); end
        rst_n = 1'b0; #1;
        n_cmp++; if (MemWrite !== 1'b0) begin n_fail++; $display("FAIL rst_acc_memwrite_drop got %b exp 0", MemWrite); end
        @(posedge clk); @(negedge clk);
        n_cmp++; if (rsp_valid !== 2'b00 || cnt0 !== 16'd0 || cnt1 !== 16'd0) begin
            n_fail++; $display("FAIL rst_acc_state got v=%b cnt=%0d/%0d exp 00 0/0", rsp_valid, cnt0, cnt1); end
        rst_n = 1'b1;
        @(negedge clk);
        issue(0, 1'b0, 1'b0, 2'd3, 64'h40, 64'd0, v, d, e, lat, mw);
        n_cmp++; if (d !== ref_load(64'h40, 2'd3, 1'b0) || v !== 2'b01 || lat != 2) begin
            n_fail++; $display("FAIL rst_acc_prior got %h v=%b lat=%0d exp %h v=01 lat=2", d, v, lat, ref_load(64'h40, 2'd3, 1'b0)); end
    endtask

    task automatic test_saturation();
        int pulses[$];
        s_req_valid = 2'b01;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (s_rsp_valid != 2'b00) pulses.push_back(k);
            if (pulses.size() == 5) break;
        end
        s_req_valid = 2'b00;
        n_cmp++; if (pulses.size() != 5) begin n_fail++; $display("FAIL sat_pulses got %0d exp 5", pulses.size()); end
        for (int i = 1; i < pulses.size(); i++) begin
            n_cmp++; if (pulses[i] - pulses[i-1] != 3) begin n_fail++; $display("FAIL b2b_spacing[%0d] got %0d exp 3", i, pulses[i] - pulses[i-1]); end
        end
        @(negedge clk);
        n_cmp++; if (s_cnt0 !== 2'd3 || s_cnt1 !== 2'd0) begin n_fail++; $display("FAIL sat_cnt got %0d/%0d exp 3/0", s_cnt0, s_cnt1); end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_store_load_dword();
        test_byte_sign();
        test_misaligned();
        test_random();
        test_reset_in_access();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Two-port arbiter and sequencer in front of the byte-addressed data memory. It shares the single data-memory port between requester 0 (load/store unit) and requester 1 (debug/DMA loader). Each requester uses a valid/ready request channel and a 1-cycle response pulse. The block grants round-robin, checks alignment, drives the memory control signals for exactly one cycle and returns the registered result.

Parameters:
REG_WIDTH, 64, data/address width; must match the data memory.
CNT_WIDTH, 16, width of per-requester completed-transaction counters.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst_n  input  1  asynchronous, active-low reset.
req_valid  input  2  bit i: requester i presents a request.
req_ready  output  2  bit i: requester i's request is accepted this cycle.
req_write  input  2  bit i: 1=store, 0=load.
req_sign  input  2  bit i: MemSign for requester i (0=sign-extend, 1=zero-extend).
req_width0/req_width1  input  2 each  0=byte, 1=half, 2=word, 3=double.
req_addr0/req_addr1  input  REG_WIDTH each  byte address.
req_wdata0/req_wdata1  input  REG_WIDTH each  store data.
rsp_valid  output  2  bit i: one-cycle response pulse to requester i.
rsp_rdata  output  REG_WIDTH  load data; 0 for stores and errors.
rsp_err  output  1  misaligned access; qualified by rsp_valid.
MemRead, MemWrite, MemSign  output  1 each  memory controls.
MemWidth  output  2  memory access width.
full_addr, wdata  output  REG_WIDTH each  memory address and store data.
rdata  input  REG_WIDTH  memory read data; combinational from full_addr.
cnt0, cnt1  output  CNT_WIDTH each  completed transactions per requester, saturating.

Behaviour:
- FSM states: IDLE -> ACCESS -> RESP -> IDLE. One transaction in flight. Throughput is 1 transaction per 3 cycles.
- Reset: async on rst_n low.
  - State = IDLE, rr pointer = 0 (requester 0 preferred), all latched request fields = 0.
  - Outputs: req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, cnt0=cnt1=0, all Mem* outputs and full_addr/wdata = 0.
- IDLE:
  - req_ready is combinational, asserted only in IDLE, to at most one requester.
  - If only one requester is valid, it wins. If both are valid, the winner is the rr pointer.
  - On the winning handshake (valid & ready), latch owner id, write, sign, width, addr, wdata. Go to ACCESS.
- Alignment check on the latched request:
  - width 1 needs addr[0]=0; width 2 needs addr[1:0]=0; width 3 needs addr[2:0]=0; width 0 is always aligned.
- ACCESS (exactly 1 cycle):
  - Aligned: drive full_addr, wdata, MemWidth, MemSign from latched fields, with MemWrite=write and MemRead=~write. The store commits at the ACCESS->RESP edge. For a load, register rdata into rsp_rdata at that edge.
  - Misaligned: MemRead=MemWrite=0, set the err flag, rsp_rdata=0.
  - Go to RESP.
  - Outside ACCESS, all Mem* controls, full_addr and wdata are 0.
- RESP (exactly 1 cycle):
  - rsp_valid[owner]=1; rsp_rdata and rsp_err hold their registered values. Responses have no back-pressure.
  - Increment cnt[owner], saturating at 2^CNT_WIDTH-1. Errors also count.
  - Set rr pointer = ~owner. Go to IDLE.
  - rsp_rdata and rsp_err are cleared to 0 on entry to IDLE.
- Requests presented outside IDLE are ignored (ready=0). Requesters must hold valid and fields stable until ready.
- Reset asserted in ACCESS: MemWrite drops immediately (asynchronously). No memory write occurs and no response is issued.
- req_sign is passed through unchanged. It is ignored by the memory for stores and width 3.

Test Plan:
- Requester 0 stores width 3, addr 0x10, data 0x1122334455667788; then loads width 3 from 0x10 -> second rsp_valid=2'b01, rsp_rdata=0x1122334455667788, rsp_err=0; each rsp_valid arrives 2 cycles after its handshake.
- Requester 0 stores byte 0x80 at 0x20, then loads width 0 from 0x20 with sign=0 -> rsp_rdata=0xFFFFFFFFFFFFFF80; the same load with sign=1 -> rsp_rdata=0x80.
- Both requesters hold valid continuously from reset -> grant order is 0,1,0,1; cnt0=cnt1=2 after 4 responses; req_ready is never 2'b11.
- Requester 1 stores width 2 to addr 0x13 -> MemWrite stays 0 throughout; rsp_valid=2'b10 with rsp_err=1 and rsp_rdata=0; cnt1 increments by 1.
- Pull rst_n low while a store is in ACCESS -> MemWrite=0 immediately; after release, a load of that address returns the prior contents; state is IDLE and cnt0=cnt1=0.
- Set CNT_WIDTH=2 and run 5 requester-0 loads -> cnt0 stops at 3.
